// File: rtl/draw_pair_writer_if.sv
// Framebuffer write port for draw_pair_writer: one packed pixel pair per beat.
// valid/ready: a beat transfers on a clock edge where fb_valid && fb_ready; once
// fb_valid rises, fb_addr/fb_wdata hold and fb_valid stays high until that transfer.
interface draw_pair_writer_if #(
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 4
);
  logic                 fb_valid;
  logic                 fb_ready;
  logic [ADDR_W-2:0]    fb_addr;
  logic [2*PIX_W-1:0]   fb_wdata;

  modport master (output fb_valid, fb_addr, fb_wdata, input fb_ready);
  modport slave  (input fb_valid, fb_addr, fb_wdata, output fb_ready);
endinterface

// File: rtl/draw_pair_writer.sv
// Reads even/odd pixel pairs from a dual-port sprite ROM and writes them as packed
// framebuffer words through a small FIFO. Optional pair checker: `define DRAW_PAIR_CHECK_EN.
module draw_pair_writer #(
  parameter int                ADDR_W      = 14,
  parameter int                PIX_W       = 4,
  parameter int                DEPTH       = 4,
  parameter logic [ADDR_W-1:0] LAST_ADDR_A = 14'd5888
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] rom_addr_a,
  output logic [ADDR_W-1:0] rom_addr_b,
  input  logic [PIX_W-1:0]  rom_q_a,
  input  logic [PIX_W-1:0]  rom_q_b,
  draw_pair_writer_if.master fb,
  output logic [ADDR_W-1:0] pairs_done,
  output logic              overflow,
  output logic              done
`ifdef DRAW_PAIR_CHECK_EN
  ,
  output logic              pair_err
`endif
);

  localparam int ENT_W = ADDR_W - 1 + 2 * PIX_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-2:0] LAST_WORD = LAST_ADDR_A[ADDR_W-1:1];

  assign rom_addr_a = addr_a;
  assign rom_addr_b = addr_b;

  // Stage 0: a pair is new when the counter moved, or on the first cycle after reset.
  logic              first;
  logic [ADDR_W-1:0] last_a;
  logic              new_pair;
  logic              s1_valid;
  logic [ADDR_W-2:0] s1_word;

  always_comb new_pair = first | (addr_a != last_a);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first    <= 1'b1;
      last_a   <= '0;
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else begin
      s1_valid <= new_pair;
      if (new_pair) begin
        first   <= 1'b0;
        last_a  <= addr_a;
        s1_word <= addr_a[ADDR_W-1:1];
      end
    end
  end

  // FIFO: head entry is read straight from the storage registers.
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, full, wr_en;
  logic [ENT_W-1:0] head;

  always_comb begin
    push  = s1_valid;
    pop   = (count != '0) && fb.fb_ready;
    full  = (count == FULL_CNT);
    wr_en = push && (!full || pop);
    head  = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {s1_word, rom_q_b, rom_q_a};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign fb.fb_valid = (count != '0);
  assign fb.fb_addr  = head[ENT_W-1 -: ADDR_W-1];
  assign fb.fb_wdata = head[2*PIX_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pairs_done <= '0;
      done       <= 1'b0;
    end else if (pop) begin
      pairs_done <= pairs_done + ADDR_W'(1);
      if (head[ENT_W-1 -: ADDR_W-1] == LAST_WORD) done <= 1'b1;
    end
  end

`ifdef DRAW_PAIR_CHECK_EN
  // A malformed pair is flagged but still flows through to the framebuffer.
  logic pair_bad;
  always_comb pair_bad = (addr_b != {addr_a[ADDR_W-1:1], 1'b1}) | addr_a[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    pair_err <= 1'b0;
    else if (new_pair && pair_bad) pair_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_draw_pair_writer.sv
// Bench for draw_pair_writer: transaction-level model with a word queue, compared
// on every falling edge, plus directed scenarios with hand-computed expectations.
module tb_draw_pair_writer;
  localparam int ADDR_W = 14;
  localparam int PIX_W  = 4;
  localparam int DEPTH  = 4;
  localparam int W      = ADDR_W - 1 + 2 * PIX_W;
  localparam int LAST_WORD = 5888 / 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic [ADDR_W-1:0] rom_addr_a, rom_addr_b;
  logic [PIX_W-1:0]  rom_q_a = '0, rom_q_b = '0;
  logic [ADDR_W-1:0] pairs_done;
  logic              overflow, done;
`ifdef DRAW_PAIR_CHECK_EN
  logic              pair_err;
`endif

  draw_pair_writer_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) fb_if ();

  draw_pair_writer #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .DEPTH(DEPTH), .LAST_ADDR_A(14'd5888)) dut (
    .clk(clk), .reset(reset), .addr_a(addr_a), .addr_b(addr_b),
    .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
    .rom_q_a(rom_q_a), .rom_q_b(rom_q_b), .fb(fb_if.master),
    .pairs_done(pairs_done), .overflow(overflow), .done(done)
`ifdef DRAW_PAIR_CHECK_EN
    , .pair_err(pair_err)
`endif
  );

  // ---------------- clock / ROM ----------------
  always #5 clk = ~clk;

  // Synchronous ROM whose data is the low address bits.
  always @(posedge clk) begin
    rom_q_a <= rom_addr_a[PIX_W-1:0];
    rom_q_b <= rom_addr_b[PIX_W-1:0];
  end

  int edges_since_rel;
  always @(posedge clk or negedge reset)
    if (!reset) edges_since_rel <= 0;
    else        edges_since_rel <= edges_since_rel + 1;

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [W-1:0] exp_q[$];
  bit           m_first, m_s1, m_ovf, m_done, m_perr;
  logic [ADDR_W-1:0] m_last;
  logic [W-1:0] m_s1_ent;
  int           m_pairs, accepts, lost, first_acc, last_acc, first_valid_at;

  function automatic void model_reset();
    exp_q.delete();
    m_first = 1; m_s1 = 0; m_ovf = 0; m_done = 0; m_perr = 0;
    m_last = '0; m_s1_ent = '0; m_pairs = 0;
    accepts = 0; lost = 0; first_acc = -1; last_acc = -1; first_valid_at = -1;
  endfunction

  initial model_reset();

  // Compare on the falling edge, then advance the model through the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_fb_valid", 32'(fb_if.fb_valid), 0);
      check("rst_fb_addr", 32'(fb_if.fb_addr), 0);
      check("rst_fb_wdata", 32'(fb_if.fb_wdata), 0);
      check("rst_pairs_done", 32'(pairs_done), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_done", 32'(done), 0);
      model_reset();
    end else begin
      logic [W-1:0] e;
      bit pop;
      check("fb_valid", 32'(fb_if.fb_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("fb_addr", 32'(fb_if.fb_addr), 32'(exp_q[0][W-1:2*PIX_W]));
        check("fb_wdata", 32'(fb_if.fb_wdata), 32'(exp_q[0][2*PIX_W-1:0]));
        if (first_valid_at < 0) first_valid_at = edges_since_rel;
      end
      check("pairs_done", 32'(pairs_done), 32'(m_pairs));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("done", 32'(done), 32'(m_done));
`ifdef DRAW_PAIR_CHECK_EN
      check("pair_err", 32'(pair_err), 32'(m_perr));
`endif
      pop = (exp_q.size() > 0) && fb_if.fb_ready;
      if (pop) begin
        e = exp_q.pop_front();
        m_pairs = (m_pairs + 1) % (1 << ADDR_W);
        accepts++;
        if (int'(e[W-1:2*PIX_W]) == LAST_WORD) m_done = 1;
        if (first_acc < 0) first_acc = int'(e[W-1:2*PIX_W]);
        last_acc = int'(e[W-1:2*PIX_W]);
      end
      if (m_s1) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_s1_ent);
        else begin m_ovf = 1; lost++; end
      end
      if (m_first || addr_a != m_last) begin
        m_s1 = 1; m_first = 0; m_last = addr_a;
        m_s1_ent = {addr_a[ADDR_W-1:1], addr_b[PIX_W-1:0], addr_a[PIX_W-1:0]};
        if (addr_b != (addr_a | 14'd1) || addr_a[0]) m_perr = 1;
      end else begin
        m_s1 = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [ADDR_W-1:0] a, input logic rdy);
    @(posedge clk); #1;
    addr_a = a; addr_b = a | 14'd1; fb_if.fb_ready = rdy;
  endtask

  // Hold reset for two edges with a0 presented, release just after an edge.
  task automatic do_reset(input logic [ADDR_W-1:0] a0);
    @(posedge clk); #1;
    reset = 1'b0; addr_a = a0; addr_b = a0 | 14'd1; fb_if.fb_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic drain(input logic [ADDR_W-1:0] a);
    repeat (8) drive(a, 1'b1);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    fb_if.fb_ready = 1'b1;

    // Full tail run 5632..5888, ready always high.
    do_reset(14'd5632);
    for (int k = 1; k <= 128; k++) drive(14'(5632 + 2 * k), 1'b1);
    drain(14'd5888);
    check("run_first_valid_edge", 32'(first_valid_at), 2);
    check("run_accepts", 32'(accepts), 129);
    check("run_pairs_done", 32'(pairs_done), 129);
    check("run_first_addr", 32'(first_acc), 2816);
    check("run_last_addr", 32'(last_acc), 2944);
    check("run_done", 32'(done), 1);

    // Held counter: one write only.
    do_reset(14'd5700);
    repeat (10) drive(14'd5700, 1'b1);
    drain(14'd5700);
    check("hold_pairs_done", 32'(pairs_done), 1);
    check("hold_addr", 32'(last_acc), 2850);

    // Three-cycle stall fits in the FIFO.
    do_reset(14'd1000);
    for (int i = 1; i <= 20; i++) drive(14'(1000 + 2 * i), !(i >= 5 && i < 8));
    drain(14'd1040);
    check("stall3_overflow", 32'(overflow), 0);
    check("stall3_accepts", 32'(accepts), 21);
    check("stall3_last_addr", 32'(last_acc), 520);

    // Ten-cycle stall with eight pushes landing in it: five lost.
    do_reset(14'd2000);
    for (int i = 1; i <= 40; i++)
      drive((i <= 16) ? 14'(2000 + 2 * i) : 14'd2032, !(i >= 10 && i <= 19));
    drain(14'd2032);
    check("stall10_overflow", 32'(overflow), 1);
    check("stall10_lost", 32'(lost), 5);
    check("stall10_accepts", 32'(accepts), 12);

    // Reset mid-stream, then the same address is a new pair.
    do_reset(14'd5990);
    for (int i = 1; i <= 5; i++) drive(14'(5990 + 2 * i), 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check("midrst_fb_valid", 32'(fb_if.fb_valid), 0);
    check("midrst_pairs_done", 32'(pairs_done), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drain(14'd6000);
    check("midrst_accepts", 32'(accepts), 1);
    check("midrst_addr", 32'(last_acc), 3000);

`ifdef DRAW_PAIR_CHECK_EN
    do_reset(14'd5640);
    addr_b = 14'd5643;
    @(negedge clk);
    @(negedge clk);
    check("perr_flag", 32'(pair_err), 1);
    drain(14'd5640);
    check("perr_addr", 32'(last_acc), 2820);
`endif

    // Randomized: random advances, regressions and backpressure.
    do_reset(14'd100);
    begin
      logic [ADDR_W-1:0] a;
      a = 14'd100;
      for (int i = 0; i < 800; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2:  ;
          3:        a = 14'($urandom_range(0, 8191) * 2);
          default:  a = a + 14'd2;
        endcase
        drive(a, $urandom_range(0, 9) < 7);
      end
      drain(a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
